vend_sequencer: RTL and testbench

- Front-end controller for the vending_machine core (nickel/dime/quarter pulse inputs; soda and 3-bit change-in-nickels outputs).
- Buffers coin events from the coin acceptor in a small FIFO and feeds them to the core one at a time as single-cycle pulses.
- Samples the core's soda/change result after each coin. On a sale it sequences the soda dispenser, then pays out change one nickel at a time, using req/ack handshakes to the mechanics.
- Also keeps a sales counter.

---
 rtl/vend_sequencer.sv | 166 ++++++++++++++++
 tb/tb_vend_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Front-end sequencer for the vending_machine core: queues coin events, issues them to the
// core one at a time, then drives the soda dispenser and nickel payout handshakes.
module vend_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             coin_valid_i,
    input  logic [1:0]       coin_type_i,
    output logic             coin_ready_o,
    output logic             nickel_o,
    output logic             dime_o,
    output logic             quarter_o,
    input  logic             soda_i,
    input  logic [2:0]       change_i,
    output logic             vend_req_o,
    input  logic             vend_ack_i,
    output logic             chg_req_o,
    input  logic             chg_ack_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] sales_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StCheck,
        StVend,
        StChange
    } state_e;

    state_e            state_q;
    logic [1:0]        fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic [2:0]        chg_cnt_q;
    logic [CNT_W-1:0]  sales_q;
    logic              nickel_q;
    logic              dime_q;
    logic              quarter_q;
    logic              vend_req_q;
    logic              chg_req_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [1:0]        head;
    logic [2:0]        chg_clamped;

    assign fifo_full   = (count_q == DepthCnt);
    assign fifo_empty  = (count_q == '0);
    assign head        = fifo_mem_q[rd_ptr_q];
    // Type 00 completes the handshake but is dropped.
    assign push        = coin_valid_i && !fifo_full && (coin_type_i != 2'b00);
    assign pop         = (state_q == StIssue);
    assign chg_clamped = (change_i > 3'd4) ? 3'd4 : change_i;

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= coin_type_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            chg_cnt_q  <= '0;
            sales_q    <= '0;
            nickel_q   <= 1'b0;
            dime_q     <= 1'b0;
            quarter_q  <= 1'b0;
            vend_req_q <= 1'b0;
            chg_req_q  <= 1'b0;
        end else begin
            nickel_q  <= 1'b0;
            dime_q    <= 1'b0;
            quarter_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        // Pulse is registered here so it is high for the whole ISSUE cycle.
                        nickel_q  <= (head == 2'b01);
                        dime_q    <= (head == 2'b10);
                        quarter_q <= (head == 2'b11);
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (soda_i) begin
                        chg_cnt_q  <= chg_clamped;
                        vend_req_q <= 1'b1;
                        state_q    <= StVend;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StVend: begin
                    if (vend_ack_i) begin
                        vend_req_q <= 1'b0;
                        if (sales_q != '1) begin
                            sales_q <= sales_q + 1'b1;
                        end
                        if (chg_cnt_q != 3'd0) begin
                            chg_req_q <= 1'b1;
                            state_q   <= StChange;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StChange: begin
                    if (chg_ack_i) begin
                        chg_cnt_q <= chg_cnt_q - 1'b1;
                        if (chg_cnt_q == 3'd1) begin
                            chg_req_q <= 1'b0;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign coin_ready_o = !fifo_full;
    assign nickel_o     = nickel_q;
    assign dime_o       = dime_q;
    assign quarter_o    = quarter_q;
    assign vend_req_o   = vend_req_q;
    assign chg_req_o    = chg_req_q;
    assign busy_o       = (state_q != StIdle) || !fifo_empty;
    assign sales_o      = sales_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer; a scripted stand-in for the core answers each coin pulse.
module tb_vend_sequencer;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 16;
    localparam logic [1:0]  NICKEL     = 2'b01;
    localparam logic [1:0]  DIME       = 2'b10;
    localparam logic [1:0]  QUARTER    = 2'b11;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             coin_valid_i = 1'b0;
    logic [1:0]       coin_type_i = 2'b00;
    logic             coin_ready_o;
    logic             nickel_o;
    logic             dime_o;
    logic             quarter_o;
    logic             soda_i = 1'b0;
    logic [2:0]       change_i = 3'd0;
    logic             vend_req_o;
    logic             vend_ack_i = 1'b0;
    logic             chg_req_o;
    logic             chg_ack_i = 1'b0;
    logic             busy_o;
    logic [CNT_W-1:0] sales_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_cyc = 0;
    int chg_req_cycles = 0;
    logic [1:0] pulse_type [$];
    int         pulse_cyc [$];
    logic [3:0] resp_q [$];

    vend_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .coin_valid_i(coin_valid_i),
        .coin_type_i (coin_type_i),
        .coin_ready_o(coin_ready_o),
        .nickel_o    (nickel_o),
        .dime_o      (dime_o),
        .quarter_o   (quarter_o),
        .soda_i      (soda_i),
        .change_i    (change_i),
        .vend_req_o  (vend_req_o),
        .vend_ack_i  (vend_ack_i),
        .chg_req_o   (chg_req_o),
        .chg_ack_i   (chg_ack_i),
        .busy_o      (busy_o),
        .sales_o     (sales_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core stand-in: registered reply {soda, change} one cycle after each pulse.
    always @(posedge clk_i) begin
        logic [3:0] r;
        r = 4'd0;
        if (nickel_o || dime_o || quarter_o) begin
            if (resp_q.size() > 0) r = resp_q.pop_front();
        end
        soda_i   <= r[3];
        change_i <= r[2:0];
    end

    always @(negedge clk_i) begin
        if (chg_req_o) chg_req_cycles++;
        if (nickel_o || dime_o || quarter_o) begin
            check("pulse_onehot", 32'({nickel_o, dime_o, quarter_o}) & 32'({nickel_o, dime_o,
                  quarter_o} - 3'd1), 32'd0);
            pulse_type.push_back(quarter_o ? QUARTER : (dime_o ? DIME : NICKEL));
            pulse_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        coin_valid_i = 1'b0;
        vend_ack_i = 1'b0;
        chg_ack_i = 1'b0;
        resp_q.delete();
        tick(2);
        rst_i = 1'b0;
        tick(1);
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!coin_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("coin_accepted", coin_ready_o, 1'b1);
        @(negedge clk_i);
        push_cyc = cyc;
        coin_valid_i = 1'b0;
        coin_type_i = 2'b00;
    endtask

    task automatic push_coin(input logic [1:0] t);
        coin_valid_i = 1'b1;
        coin_type_i = t;
        wait_accept();
    endtask

    task automatic wait_vend_req();
        int n = 0;
        while (!vend_req_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("vend_req_seen", vend_req_o, 1'b1);
    endtask

    task automatic ack_vend();
        vend_ack_i = 1'b1;
        tick(1);
        vend_ack_i = 1'b0;
    endtask

    task automatic wait_pulses(input int want);
        int n = 0;
        while (pulse_type.size() < want && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("pulse_count", pulse_type.size(), want);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("busy_clear", busy_o, 1'b0);
    endtask

    initial begin
        int base;
        int cbase;
        int n;
        logic [1:0] exp3 [6];

        // Reset state
        do_reset();
        check("rst_ready", coin_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_sales", sales_o, 0);
        check("rst_reqs", {vend_req_o, chg_req_o}, 2'b00);
        check("rst_pulses", {nickel_o, dime_o, quarter_o}, 3'b000);

        // Single quarter, one nickel of change
        base = pulse_type.size();
        resp_q.push_back({1'b1, 3'd1});
        push_coin(QUARTER);
        wait_vend_req();
        check("t1_pulse_type", pulse_type[base], QUARTER);
        check("t1_pulse_cyc", pulse_cyc[base], push_cyc + 1);
        tick(2);
        check("t1_vend_held", vend_req_o, 1'b1);
        check("t1_sales_pre", sales_o, 0);
        vend_ack_i = 1'b1;
        tick(1);
        vend_ack_i = 1'b0;
        check("t1_vend_drop", vend_req_o, 1'b0);
        check("t1_sales", sales_o, 1);
        check("t1_chg_req", chg_req_o, 1'b1);
        chg_ack_i = 1'b1;
        tick(1);
        chg_ack_i = 1'b0;
        check("t1_chg_drop", chg_req_o, 1'b0);
        check("t1_busy", busy_o, 1'b0);

        // Dime, dime, nickel; sale on the third with no change
        do_reset();
        base = pulse_type.size();
        cbase = chg_req_cycles;
        resp_q.push_back(4'd0);
        resp_q.push_back(4'd0);
        resp_q.push_back({1'b1, 3'd0});
        push_coin(DIME);
        push_coin(DIME);
        push_coin(NICKEL);
        wait_vend_req();
        check("t2_type0", pulse_type[base], DIME);
        check("t2_type1", pulse_type[base + 1], DIME);
        check("t2_type2", pulse_type[base + 2], NICKEL);
        // IDLE -> ISSUE -> CHECK -> IDLE gives three cycles between pulses
        check("t2_gap01", pulse_cyc[base + 1] - pulse_cyc[base], 3);
        check("t2_gap12", pulse_cyc[base + 2] - pulse_cyc[base + 1], 3);
        ack_vend();
        check("t2_sales", sales_o, 1);
        check("t2_no_chg", chg_req_cycles - cbase, 0);
        wait_idle();

        // FIFO fills while the vend is stalled
        do_reset();
        base = pulse_type.size();
        resp_q.push_back({1'b1, 3'd0});
        push_coin(QUARTER);
        wait_vend_req();
        push_coin(NICKEL);
        push_coin(DIME);
        push_coin(QUARTER);
        check("t3_ready_3of4", coin_ready_o, 1'b1);
        push_coin(NICKEL);
        check("t3_full", coin_ready_o, 1'b0);
        coin_valid_i = 1'b1;
        coin_type_i = DIME;
        tick(3);
        check("t3_still_full", coin_ready_o, 1'b0);
        check("t3_no_issue", pulse_type.size(), base + 1);
        ack_vend();
        check("t3_sales", sales_o, 1);
        wait_accept();
        wait_pulses(base + 6);
        exp3 = '{QUARTER, NICKEL, DIME, QUARTER, NICKEL, DIME};
        for (int i = 0; i < 6; i++) check("t3_order", pulse_type[base + i], exp3[i]);
        wait_idle();

        // Nickel then quarter, two nickels of change, stray vend ack in CHANGE
        do_reset();
        resp_q.push_back(4'd0);
        resp_q.push_back({1'b1, 3'd2});
        push_coin(NICKEL);
        push_coin(QUARTER);
        wait_vend_req();
        ack_vend();
        check("t4_chg_req", chg_req_o, 1'b1);
        chg_ack_i = 1'b1;
        tick(1);
        chg_ack_i = 1'b0;
        check("t4_no_gap", chg_req_o, 1'b1);
        vend_ack_i = 1'b1;
        tick(1);
        vend_ack_i = 1'b0;
        check("t4_stray_vack_req", chg_req_o, 1'b1);
        check("t4_stray_vack_sales", sales_o, 1);
        chg_ack_i = 1'b1;
        tick(1);
        chg_ack_i = 1'b0;
        check("t4_chg_fall", chg_req_o, 1'b0);
        check("t4_busy", busy_o, 1'b0);

        // Invalid coin type is accepted and dropped
        do_reset();
        base = pulse_type.size();
        coin_valid_i = 1'b1;
        coin_type_i = 2'b00;
        tick(1);
        check("t5_ready", coin_ready_o, 1'b1);
        tick(1);
        coin_valid_i = 1'b0;
        check("t5_busy", busy_o, 1'b0);
        tick(4);
        check("t5_no_pulse", pulse_type.size(), base);

        // Reset during payout with three nickels owed and a coin queued
        do_reset();
        resp_q.push_back({1'b1, 3'd3});
        push_coin(QUARTER);
        wait_vend_req();
        ack_vend();
        check("t6_chg_req", chg_req_o, 1'b1);
        push_coin(NICKEL);
        check("t6_busy_pre", busy_o, 1'b1);
        base = pulse_type.size();
        #2 rst_i = 1'b1;
        #1;
        check("t6_chg_drop", chg_req_o, 1'b0);
        check("t6_sales", sales_o, 0);
        check("t6_busy", busy_o, 1'b0);
        check("t6_ready", coin_ready_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick(6);
        check("t6_queue_dropped", pulse_type.size(), base);
        check("t6_chg_idle", chg_req_o, 1'b0);

        // change_i above 4 clamps; chg_ack held through VEND has no effect
        resp_q.push_back({1'b1, 3'd7});
        push_coin(QUARTER);
        wait_vend_req();
        chg_ack_i = 1'b1;
        tick(2);
        check("t7_vend_hold", vend_req_o, 1'b1);
        check("t7_no_chg", chg_req_o, 1'b0);
        ack_vend();
        n = 0;
        while (chg_req_o && n < 20) begin
            tick(1);
            n++;
        end
        chg_ack_i = 1'b0;
        check("t7_clamp4", n, 4);
        check("t7_sales", sales_o, 1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
